text_render_pipeline: RTL and testbench

- Parametrised, pipelined successor to the combinational text renderer: maps the VGA pixel position to a text cell, reads the character and attribute from the text buffer, applies hardware scroll, attribute blink and a blinking cursor, and emits a registered pixel with colour indices.
- Sits between the VGA timing generator and the RGB mux.
- Tolerates a synchronous (registered) text-buffer read through a fixed, parametrised latency.

---
 rtl/text_render_pipeline_if.sv | 46 ++++
 rtl/text_render_pipeline.sv | 180 ++++++++++++++++++
 tb/tb_text_render_pipeline.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_render_pipeline_if.sv
// Pixel, text-buffer, glyph-ROM and colour-output bundle of the text renderer.
// master: timing/buffer/ROM side; slave: text_render_pipeline.
interface text_render_pipeline_if #(
    parameter int COLS        = 80,
    parameter int ROWS        = 30,
    parameter int CHAR_WIDTH  = 8,
    parameter int CHAR_HEIGHT = 16
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int HW = $clog2(CHAR_HEIGHT);

    logic [9:0]            pixel_x;
    logic [9:0]            pixel_y;
    logic                  video_on;
    logic                  frame_start;
    logic [RW-1:0]         scroll_row;
    logic                  cursor_en;
    logic [CW-1:0]         cursor_x;
    logic [RW-1:0]         cursor_y;
    logic [CW-1:0]         read_x;
    logic [RW-1:0]         read_y;
    logic [6:0]            char_in;
    logic [7:0]            attr_in;
    logic [6:0]            rom_code;
    logic [HW-1:0]         rom_row;
    logic [CHAR_WIDTH-1:0] rom_line;
    logic                  de_out;
    logic                  text_bit_on;
    logic [2:0]            fg_idx;
    logic [2:0]            bg_idx;

    modport master (
        output pixel_x, pixel_y, video_on, frame_start, scroll_row,
        output cursor_en, cursor_x, cursor_y, char_in, attr_in, rom_line,
        input  read_x, read_y, rom_code, rom_row,
        input  de_out, text_bit_on, fg_idx, bg_idx
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_start, scroll_row,
        input  cursor_en, cursor_x, cursor_y, char_in, attr_in, rom_line,
        output read_x, read_y, rom_code, rom_row,
        output de_out, text_bit_on, fg_idx, bg_idx
    );
endinterface

// File: rtl/text_render_pipeline.sv
// Pipelined text-mode renderer: pixel position -> text cell -> buffer read ->
// glyph lookup -> scroll/blink/cursor/reverse -> registered pixel + colours.
// Ports: clk, reset (async, active-high), bus (text_render_pipeline_if.slave):
//   pixel_x/y, video_on, frame_start, scroll_row, cursor_* in; read_x/y out;
//   char_in/attr_in in; rom_code/rom_row out, rom_line in;
//   de_out, text_bit_on, fg_idx, bg_idx out (latency BUF_LATENCY+1).
// Macro TEXT_RENDER_SCROLL_EN: enables the frame-latched hardware scroll.
module text_render_pipeline #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CHAR_WIDTH   = 8,
    parameter int CHAR_HEIGHT  = 16,
    parameter int BUF_LATENCY  = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    text_render_pipeline_if.slave  bus
);
    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int GXW = $clog2(CHAR_WIDTH);
    localparam int GYW = $clog2(CHAR_HEIGHT);
    localparam int BCW = $clog2(BLINK_FRAMES + 1);
    localparam int SBW = 3 + GXW + GYW;

    // ---------------- stage 0: cell mapping ----------------
    logic [9:0]    cx;
    logic [9:0]    cy;
    logic          in_range;
    logic          hit;
    logic [RW-1:0] row_y;

    assign cx       = bus.pixel_x >> GXW;
    assign cy       = bus.pixel_y >> GYW;
    assign in_range = (cx < 10'(COLS)) && (cy < 10'(ROWS));

    // An off-screen cursor can only match an off-screen cell,
    // which the in_range gating later blanks.
    assign hit = bus.cursor_en
              && (cx == 10'(bus.cursor_x))
              && (cy == 10'(bus.cursor_y));

`ifdef TEXT_RENDER_SCROLL_EN
    logic [RW-1:0] scroll_q;
    logic [RW-1:0] scroll_d;
    logic [RW:0]   ysum;
    logic [RW:0]   ywrap;

    always_comb begin
        scroll_d = scroll_q;
        if (bus.frame_start) scroll_d = bus.scroll_row;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) scroll_q <= '0;
        else       scroll_q <= scroll_d;
    end

    // Both operands are < ROWS, so one conditional subtract is a full mod.
    assign ysum  = {1'b0, cy[RW-1:0]} + {1'b0, scroll_q};
    assign ywrap = (ysum >= (RW+1)'(ROWS)) ? ysum - (RW+1)'(ROWS) : ysum;
    assign row_y = ywrap[RW-1:0];
`else
    logic unused_scroll;
    assign unused_scroll = ^bus.scroll_row;
    assign row_y         = cy[RW-1:0];
`endif

    assign bus.read_x = in_range ? cx[CW-1:0] : '0;
    assign bus.read_y = in_range ? row_y      : '0;

    // ---------------- side-band delay line ----------------
    logic [SBW-1:0] sb_in;
    logic [SBW-1:0] sb_out;

    assign sb_in = {bus.video_on, in_range, hit,
                    bus.pixel_x[GXW-1:0], bus.pixel_y[GYW-1:0]};

    generate
        if (BUF_LATENCY == 0) begin : g_wire
            assign sb_out = sb_in;
        end else begin : g_dly
            logic [SBW-1:0] sb_q [BUF_LATENCY];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < BUF_LATENCY; i++) sb_q[i] <= '0;
                end else begin
                    sb_q[0] <= sb_in;
                    for (int i = 1; i < BUF_LATENCY; i++) sb_q[i] <= sb_q[i-1];
                end
            end

            assign sb_out = sb_q[BUF_LATENCY-1];
        end
    endgenerate

    logic           vo_s;
    logic           inr_s;
    logic           hit_s;
    logic [GXW-1:0] gcol_s;
    logic [GYW-1:0] grow_s;

    assign {vo_s, inr_s, hit_s, gcol_s, grow_s} = sb_out;

    // ---------------- blink counter ----------------
    logic [BCW-1:0] bcnt_q;
    logic [BCW-1:0] bcnt_d;
    logic           blink_q;
    logic           blink_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        if (bus.frame_start) begin
            if (bcnt_q == BCW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q  <= '0;
            blink_q <= 1'b1;
        end else begin
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
        end
    end

    // ---------------- stage 1: glyph + pixel rules ----------------
    logic       glyph_bit;
    logic       on_d;
    logic [2:0] fg_d;
    logic [2:0] bg_d;

    assign bus.rom_code = bus.char_in;
    assign bus.rom_row  = grow_s;

    // MSB is the leftmost pixel; ~col == CHAR_WIDTH-1-col for a power of two.
    assign glyph_bit = bus.rom_line[~gcol_s];

    always_comb begin
        on_d = glyph_bit && !(bus.attr_in[6] && !blink_q);
        on_d = on_d ^ (bus.attr_in[7] ^ (hit_s && blink_q));
        on_d = on_d && inr_s && vo_s;
        fg_d = inr_s ? bus.attr_in[2:0] : 3'd0;
        bg_d = inr_s ? bus.attr_in[5:3] : 3'd0;
    end

    // ---------------- output register ----------------
    logic       de_q;
    logic       on_q;
    logic [2:0] fg_q;
    logic [2:0] bg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q <= 1'b0;
            on_q <= 1'b0;
            fg_q <= 3'd0;
            bg_q <= 3'd0;
        end else begin
            de_q <= vo_s;
            on_q <= on_d;
            fg_q <= fg_d;
            bg_q <= bg_d;
        end
    end

    assign bus.de_out      = de_q;
    assign bus.text_bit_on = on_q;
    assign bus.fg_idx      = fg_q;
    assign bus.bg_idx      = bg_q;
endmodule

// File: tb/tb_text_render_pipeline.sv
// Self-checking bench for text_render_pipeline: vector table, directed
// corner sequences and a random pixel stream against a cell-level model.
module tb_text_render_pipeline;
    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int CHW  = 8;
    localparam int CHH  = 16;
    localparam int BL   = 1;
    localparam int BF   = 2;
    localparam int LAT  = BL + 1;
    localparam int BLI  = (BL == 0) ? 0 : BL - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    text_render_pipeline_if #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_WIDTH(CHW), .CHAR_HEIGHT(CHH)
    ) bus ();

    text_render_pipeline #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_WIDTH(CHW), .CHAR_HEIGHT(CHH),
        .BUF_LATENCY(BL), .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- text buffer + glyph ROM models ----------------
    logic [6:0]  mem_c [ROWS][COLS];
    logic [7:0]  mem_a [ROWS][COLS];
    logic [14:0] rd_now;
    logic [14:0] rd_q [4];

    function automatic logic [7:0] glyph(input logic [6:0] code, input int row);
        if (code == 7'd0)   return 8'h00;
        if (code == 7'h7F)  return 8'hFF;
        return 8'((int'(code) * 37 + row * 91) ^ (int'(code) >> 2) ^ (row << 3));
    endfunction

    always_comb bus.rom_line = glyph(bus.rom_code, int'(bus.rom_row));

    always_comb begin
        rd_now = '0;
        if (int'(bus.read_x) < COLS && int'(bus.read_y) < ROWS)
            rd_now = {mem_c[int'(bus.read_y)][int'(bus.read_x)],
                      mem_a[int'(bus.read_y)][int'(bus.read_x)]};
    end

    always @(posedge clk) begin
        rd_q[0] <= rd_now;
        for (int i = 1; i < 4; i++) rd_q[i] <= rd_q[i-1];
    end

    always_comb begin
        if (BL == 0) {bus.char_in, bus.attr_in} = rd_now;
        else         {bus.char_in, bus.attr_in} = rd_q[BLI];
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       de;
        logic       on;
        logic [2:0] fg;
        logic [2:0] bg;
        logic [4:0] tag;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   nfs = 0;
    int   scroll_m = 0;
    int   tag_on [32];
    int   tag_fg [32];

    function automatic exp_t model(input int x, input int y, input logic vo,
                                   input logic [4:0] tag);
        exp_t       e;
        int         cx, cy, by;
        logic [6:0] ch;
        logic [7:0] at;
        logic [7:0] gl;
        logic       g, ph, hit, on;
        e     = '0;
        e.tag = tag;
        e.de  = vo;
        cx    = x / CHW;
        cy    = y / CHH;
        if (!(cx < COLS && cy < ROWS)) return e;
        by  = (cy + scroll_m) % ROWS;
        ch  = mem_c[by][cx];
        at  = mem_a[by][cx];
        gl  = glyph(ch, y % CHH);
        g   = gl[CHW - 1 - (x % CHW)];
        ph  = ((nfs / BF) % 2) == 0;
        hit = bus.cursor_en && cx == int'(bus.cursor_x) && cy == int'(bus.cursor_y);
        on  = g && !(at[6] && !ph);
        if (at[7] != (hit && ph)) on = !on;
        e.on = on && vo;
        e.fg = at[2:0];
        e.bg = at[5:3];
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int x, input int y, input logic vo, input logic fs,
                         input logic [4:0] tag);
        exp_t e;
        bus.pixel_x     = 10'(x);
        bus.pixel_y     = 10'(y);
        bus.video_on    = vo;
        bus.frame_start = fs;
        e = model(x, y, vo, tag);
        expq.push_back(e);
        if (fs) begin
            nfs++;
`ifdef TEXT_RENDER_SCROLL_EN
            scroll_m = int'(bus.scroll_row);
`endif
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
        if (expq.size() >= LAT) begin
            e = expq.pop_front();
            checks++;
            if (bus.de_out !== e.de || bus.text_bit_on !== e.on ||
                bus.fg_idx !== e.fg || bus.bg_idx !== e.bg) begin
                errors++;
                $display("FAIL pix t=%0t got de=%b on=%b fg=%0d bg=%0d want de=%b on=%b fg=%0d bg=%0d",
                         $time, bus.de_out, bus.text_bit_on, bus.fg_idx, bus.bg_idx,
                         e.de, e.on, e.fg, e.bg);
            end
            if (e.tag != 0) begin
                tag_on[e.tag] += int'(bus.text_bit_on);
                tag_fg[e.tag] = int'(bus.fg_idx);
            end
        end
    endtask

    task automatic cyc(input int x, input int y, input logic vo, input logic fs,
                       input logic [4:0] tag);
        drive(x, y, vo, fs, tag);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 600, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if (bus.de_out !== 1'b0 || bus.text_bit_on !== 1'b0 ||
            bus.fg_idx !== 3'd0 || bus.bg_idx !== 3'd0) begin
            errors++;
            $display("FAIL %s got de=%b on=%b fg=%0d bg=%0d want all 0",
                     name, bus.de_out, bus.text_bit_on, bus.fg_idx, bus.bg_idx);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Asserted mid-cycle (asynchronous); a frame_start during reset must be lost.
    task automatic do_reset();
        reset           = 1'b1;
        bus.frame_start = 1'b1;
        bus.pixel_x     = '0;
        bus.pixel_y     = '0;
        bus.video_on    = 1'b1;
        expq.delete();
        nfs      = 0;
        scroll_m = 0;
        #1;
        chk_zero("reset_async");
        @(posedge clk);
        #1;
        chk_zero("reset_hold");
        bus.frame_start = 1'b0;
        reset           = 1'b0;
        for (int i = 0; i < LAT - 1; i++) expq.push_back('0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   x;
        int   y;
        logic vo;
        int   rx;
        int   ry;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #10_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int blink_exp [5];

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mem_c[r][c] = 7'($urandom);
                mem_a[r][c] = 8'($urandom);
            end
        for (int i = 0; i < 32; i++) begin
            tag_on[i] = 0;
            tag_fg[i] = 0;
        end
        mem_c[0][0] = 7'd65;
        mem_a[0][0] = 8'h07;

        bus.pixel_x     = '0;
        bus.pixel_y     = '0;
        bus.video_on    = 1'b1;
        bus.frame_start = 1'b0;
        bus.scroll_row  = '0;
        bus.cursor_en   = 1'b0;
        bus.cursor_x    = '0;
        bus.cursor_y    = '0;

        // reset state and first-pixel latency
        @(posedge clk);
        #1;
        do_reset();
        cyc(0, 0, 1'b1, 1'b0, 5'd1);
        idle(LAT + 1);
        chk_int("reset_first_fg", tag_fg[1], 7);

        // address mapping table (scroll shadow is 0 after reset)
        tbl[0] = '{0,    0,    1'b1, 0,  0};
        tbl[1] = '{7,    15,   1'b1, 0,  0};
        tbl[2] = '{8,    16,   1'b1, 1,  1};
        tbl[3] = '{639,  479,  1'b1, 79, 29};
        tbl[4] = '{640,  0,    1'b1, 0,  0};
        tbl[5] = '{0,    480,  1'b1, 0,  0};
        tbl[6] = '{1023, 1023, 1'b1, 0,  0};
        tbl[7] = '{320,  160,  1'b1, 40, 10};
        tbl[8] = '{100,  200,  1'b0, 12, 12};
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].vo, 1'b0, 5'd0);
            #1;
            chk_int($sformatf("tbl%0d_read_x", i), int'(bus.read_x), tbl[i].rx);
            chk_int($sformatf("tbl%0d_read_y", i), int'(bus.read_y), tbl[i].ry);
            tick();
        end
        idle(LAT);

        // scroll shadow and wrap
        do_reset();
        bus.scroll_row = 5'd25;
        cyc(0, 600, 1'b0, 1'b1, 5'd0);
        drive(0, 160, 1'b1, 1'b0, 5'd0);
        #1;
`ifdef TEXT_RENDER_SCROLL_EN
        chk_int("scroll_wrap", int'(bus.read_y), 5);
`else
        chk_int("scroll_ignored", int'(bus.read_y), 10);
`endif
        tick();
        bus.scroll_row = 5'd3;
        drive(0, 160, 1'b1, 1'b0, 5'd0);
        #1;
`ifdef TEXT_RENDER_SCROLL_EN
        chk_int("scroll_midframe", int'(bus.read_y), 5);
`else
        chk_int("scroll_midframe", int'(bus.read_y), 10);
`endif
        tick();
        cyc(0, 600, 1'b0, 1'b1, 5'd0);
        drive(0, 160, 1'b1, 1'b0, 5'd0);
        #1;
`ifdef TEXT_RENDER_SCROLL_EN
        chk_int("scroll_nextframe", int'(bus.read_y), 13);
`else
        chk_int("scroll_nextframe", int'(bus.read_y), 10);
`endif
        tick();
        idle(LAT);

        // attribute blink across frames
        do_reset();
        mem_c[1][1] = 7'h7F;
        mem_a[1][1] = 8'h47;
        blink_exp   = '{1, 1, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc(0, 600, 1'b0, 1'b1, 5'd0);
            idle(2);
            cyc(8, 16, 1'b1, 1'b0, 5'(10 + k));
            idle(LAT);
        end
        for (int k = 0; k < 5; k++)
            chk_int($sformatf("blink_frame%0d", k), tag_on[10 + k], blink_exp[k]);

        // cursor cell coverage
        do_reset();
        mem_c[2][3] = 7'd0;
        mem_a[2][3] = 8'h07;
        mem_c[2][4] = 7'd0;
        mem_a[2][4] = 8'h07;
        bus.cursor_en = 1'b1;
        bus.cursor_x  = 7'd3;
        bus.cursor_y  = 5'd2;
        for (int p = 0; p < 128; p++) cyc(24 + p % 8, 32 + p / 8, 1'b1, 1'b0, 5'd2);
        for (int p = 0; p < 128; p++) cyc(32 + p % 8, 32 + p / 8, 1'b1, 1'b0, 5'd3);
        bus.cursor_en = 1'b0;
        for (int p = 0; p < 128; p++) cyc(24 + p % 8, 32 + p / 8, 1'b1, 1'b0, 5'd4);
        idle(LAT);
        chk_int("cursor_cell_on", tag_on[2], 128);
        chk_int("cursor_next_cell", tag_on[3], 0);
        chk_int("cursor_disabled", tag_on[4], 0);

        // reverse video under the cursor cancels out
        mem_c[2][5]   = 7'h7F;
        mem_a[2][5]   = 8'h87;
        bus.cursor_en = 1'b1;
        bus.cursor_x  = 7'd5;
        cyc(40, 32, 1'b1, 1'b0, 5'd5);
        idle(LAT);
        chk_int("reverse_cursor", tag_on[5], 1);

        // random stream with frame boundaries and a mid-frame reset
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mem_c[r][c] = 7'($urandom);
                mem_a[r][c] = 8'($urandom);
            end
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (i % 150 == 0) begin
                idle(BL);
                bus.scroll_row = 5'($urandom_range(ROWS - 1));
                bus.cursor_en  = 1'($urandom);
                bus.cursor_x   = 7'($urandom_range(84));
                bus.cursor_y   = 5'($urandom_range(31));
                cyc(0, 600, 1'b0, 1'b1, 5'd0);
            end else begin
                if ($urandom_range(40) == 0)
                    bus.scroll_row = 5'($urandom_range(ROWS - 1));
                cyc(int'($urandom_range(700)), int'($urandom_range(520)),
                    1'($urandom_range(3) != 0), 1'b0, 5'd0);
            end
        end
        idle(LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
